// File: rtl/lcd_pkg.sv
// Shared LCD definitions: line width, blank image and arbiter states.
// Used by the arbiter, the LCD nibble driver and client blocks.
package lcd_pkg;
    localparam int LINE_BITS = 128;
    localparam logic [LINE_BITS-1:0] BLANK_LINE = {16{8'h20}};

    typedef enum logic [2:0] {
        ST_BLANK,
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_HOLD
    } arb_state_e;
endpackage

// File: rtl/lcd_display_arbiter_if.sv
// Write handshake between the display arbiter (master)
// and the LCD nibble driver (slave).
interface lcd_display_arbiter_if;
    import lcd_pkg::*;

    logic                 drv_start;
    logic [LINE_BITS-1:0] drv_first_line;
    logic [LINE_BITS-1:0] drv_second_line;
    logic                 drv_busy;
    logic                 drv_done;

    modport master (
        output drv_start,
        output drv_first_line,
        output drv_second_line,
        input  drv_busy,
        input  drv_done
    );

    modport slave (
        input  drv_start,
        input  drv_first_line,
        input  drv_second_line,
        output drv_busy,
        output drv_done
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or
// above the pointer, wrapping; the pointer register lives outside.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic                       any_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic [NUM_REQ-1:0]         onehot_o
);
    localparam int IW = $clog2(NUM_REQ);

    logic found;

    always_comb begin
        any_o    = |req_i;
        idx_o    = '0;
        onehot_o = '0;
        found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
                found = 1'b1;
                idx_o = IW'((int'(ptr_i) + k) % NUM_REQ);
                onehot_o[(int'(ptr_i) + k) % NUM_REQ] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/lcd_display_arbiter.sv
// Shares one 2x16 LCD write engine between NUM_REQ clients:
// blank on reset, round-robin grant, write, then hold the image.
module lcd_display_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int HOLD_CYCLES    = 50_000_000,
    parameter int TIMEOUT_CYCLES = 200_000_000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*LINE_BITS-1:0]   req_first_line_i,
    input  logic [NUM_REQ*LINE_BITS-1:0]   req_second_line_i,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic [$clog2(NUM_REQ)-1:0]     owner_o,
    output logic                           owner_valid_o,
    output logic                           err_timeout_o,
    lcd_display_arbiter_if.master          drv
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic                 ov_q, ov_d;
    logic                 start_q, start_d;
    logic [LINE_BITS-1:0] l1_q, l1_d;
    logic [LINE_BITS-1:0] l2_q, l2_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic                 err_q, err_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic                 blank_q, blank_d;

    logic                 any;
    logic [IW-1:0]        win;
    logic [NUM_REQ-1:0]   win_oh;
    logic                 waiting;
    logic                 tmo_last;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .any_o    (any),
        .idx_o    (win),
        .onehot_o (win_oh)
    );

    assign waiting  = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);
    // Expiry flagged one count early so err lands TIMEOUT cycles after start.
    assign tmo_last = (tmo_q == TW'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BLANK;
            grant_q <= '0;
            owner_q <= '0;
            ov_q    <= 1'b0;
            start_q <= 1'b0;
            l1_q    <= BLANK_LINE;
            l2_q    <= BLANK_LINE;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            hold_q  <= '0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ov_q    <= ov_d;
            start_q <= start_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            hold_q  <= hold_d;
            blank_q <= blank_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BLANK: state_d = ST_WAIT_BUSY;
            ST_IDLE:  if (any) state_d = ST_START;
            ST_START: state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY, ST_WAIT_DONE: begin
                if (drv.drv_done)
                    state_d = blank_q ? ST_IDLE : ST_HOLD;
                else if (tmo_last)
                    state_d = ST_IDLE;
                else if (state_q == ST_WAIT_BUSY && drv.drv_busy)
                    state_d = ST_WAIT_DONE;
            end
            ST_HOLD:  if (hold_q == '0) state_d = ST_IDLE;
            default:  state_d = ST_BLANK;
        endcase
    end

    always_comb begin
        grant_d = '0;
        start_d = 1'b0;
        owner_d = owner_q;
        ov_d    = ov_q;
        l1_d    = l1_q;
        l2_d    = l2_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        tmo_d   = '0;
        hold_d  = hold_q;
        blank_d = blank_q;
        if (state_q == ST_BLANK) begin
            start_d = 1'b1;
            blank_d = 1'b1;
        end
        if (state_q == ST_IDLE && any) begin
            l1_d    = req_first_line_i[int'(win)*LINE_BITS +: LINE_BITS];
            l2_d    = req_second_line_i[int'(win)*LINE_BITS +: LINE_BITS];
            grant_d = win_oh;
            owner_d = win;
            ov_d    = 1'b1;
            start_d = 1'b1;
            blank_d = 1'b0;
            ptr_d   = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        end
        if (waiting) begin
            if (drv.drv_done) begin
                if (!blank_q) hold_d = HW'(HOLD_CYCLES - 1);
            end else if (tmo_last) begin
                err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
        if (state_q == ST_HOLD && hold_q != '0)
            hold_d = hold_q - 1'b1;
    end

    assign grant_o             = grant_q;
    assign owner_o             = owner_q;
    assign owner_valid_o       = ov_q;
    assign err_timeout_o       = err_q;
    assign drv.drv_start       = start_q;
    assign drv.drv_first_line  = l1_q;
    assign drv.drv_second_line = l2_q;
endmodule

// File: tb/tb_lcd_display_arbiter.sv
// Randomized bench for lcd_display_arbiter against a
// transaction-level round-robin / timing reference model.
module tb_lcd_display_arbiter;
    import lcd_pkg::*;

    localparam int N = 4;
    localparam int H = 4;
    localparam int T = 10;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N-1:0]       req = '0;
    logic [N*128-1:0]   rl1 = '0;
    logic [N*128-1:0]   rl2 = '0;
    logic [N-1:0]       grant;
    logic [1:0]         owner;
    logic               owner_valid;
    logic               err;

    lcd_display_arbiter_if bus();

    lcd_display_arbiter #(
        .NUM_REQ(N), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_i             (req),
        .req_first_line_i  (rl1),
        .req_second_line_i (rl2),
        .grant_o           (grant),
        .owner_o           (owner),
        .owner_valid_o     (owner_valid),
        .err_timeout_o     (err),
        .drv               (bus.master)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           failures = 0;
    int           cyc_n = 0;
    logic [127:0] m_l1 [N];
    logic [127:0] m_l2 [N];
    logic [127:0] exp1, exp2;
    logic [N-1:0] pending = '0;
    int           ptr = 0;
    logic         err_m = 1'b0;
    int           idle_from = 0;
    bit           hold_next = 0;
    bit           force_01 = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic rand_lines();
        for (int i = 0; i < N; i++) begin
            m_l1[i] = {$urandom, $urandom, $urandom, $urandom};
            m_l2[i] = {$urandom, $urandom, $urandom, $urandom};
            rl1[i*128 +: 128] = m_l1[i];
            rl2[i*128 +: 128] = m_l2[i];
        end
    endtask

    task automatic reset_blank();
        int d;
        rst = 1'b1;
        bus.drv_busy = 1'b0;
        bus.drv_done = 1'b0;
        tick();
        check("rst_grant", 128'(grant), 128'(0));
        check("rst_start", 128'(bus.drv_start), 128'(0));
        check("rst_owner", 128'(owner), 128'(0));
        check("rst_ov", 128'(owner_valid), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_line1", bus.drv_first_line, BLANK_LINE);
        check("rst_line2", bus.drv_second_line, BLANK_LINE);
        rst = 1'b0;
        ptr = 0;
        err_m = 1'b0;
        tick();
        check("blank_start", 128'(bus.drv_start), 128'(1));
        check("blank_grant", 128'(grant), 128'(0));
        check("blank_line1", bus.drv_first_line, BLANK_LINE);
        bus.drv_busy = 1'b1;
        repeat (2) tick();
        tick();
        bus.drv_busy = 1'b0;
        bus.drv_done = 1'b1;
        d = cyc_n;
        tick();
        bus.drv_done = 1'b0;
        check("blank_ov", 128'(owner_valid), 128'(0));
        check("blank_err", 128'(err), 128'(0));
        check("blank_start_low", 128'(bus.drv_start), 128'(0));
        check("blank_line2", bus.drv_second_line, BLANK_LINE);
        idle_from = d + 1;
        hold_next = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycles=%0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.drv_busy = 1'b0;
        bus.drv_done = 1'b0;
        rand_lines();
        tick();
        reset_blank();
        for (int t = 0; t < 40; t++) begin
            int w, k, s, d, c_apply, exp_g, mode, gap;
            rand_lines();
            if (hold_next && $urandom_range(0, 1) == 1) begin
                req = N'($urandom);
                tick();
            end
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                req = '0;
                tick();
            end
            if (force_01) begin
                pending = 4'b1001;
                force_01 = 0;
            end else begin
                if ($urandom_range(0, 2) == 0)
                    pending &= ~(N'(1) << $urandom_range(0, N-1));
                if ($urandom_range(0, 1) == 0 || pending == '0)
                    pending |= N'(1) << $urandom_range(0, N-1);
            end
            req = pending;
            c_apply = cyc_n;
            exp_g = ((c_apply > idle_from) ? c_apply : idle_from) + 1;
            w = -1;
            for (int i = 0; i < N; i++)
                if (w < 0 && pending[(ptr + i) % N]) w = (ptr + i) % N;
            exp1 = m_l1[w];
            exp2 = m_l2[w];
            k = 0;
            while (grant == '0 && k < 40) begin
                tick();
                k++;
            end
            check("gnt_cycle", 128'(cyc_n), 128'(exp_g));
            check("grant", 128'(grant), 128'(N'(1) << w));
            check("owner", 128'(owner), 128'(w));
            check("owner_valid", 128'(owner_valid), 128'(1));
            check("gnt_start", 128'(bus.drv_start), 128'(1));
            check("gnt_line1", bus.drv_first_line, exp1);
            check("gnt_line2", bus.drv_second_line, exp2);
            ptr = (w + 1) % N;
            pending[w] = 1'b0;
            req = pending;
            s = cyc_n;
            rand_lines();
            mode = (t == 20) ? 8 : $urandom_range(0, 7);
            if (mode == 8) begin
                bus.drv_busy = 1'b1;
                repeat (2) tick();
                reset_blank();
                force_01 = 1;
            end else if (mode == 0) begin
                for (int j = 1; j <= T; j++) begin
                    tick();
                    bus.drv_busy = 1'($urandom_range(0, 1));
                    if (j < T) check("err_pre", 128'(err), 128'(err_m));
                    else       check("err_tmo", 128'(err), 128'(1));
                end
                bus.drv_busy = 1'b0;
                check("tmo_ov", 128'(owner_valid), 128'(1));
                check("tmo_line1", bus.drv_first_line, exp1);
                err_m = 1'b1;
                idle_from = s + T;
                hold_next = 0;
            end else begin
                k = $urandom_range(mode[0] ? 1 : 0, T - 2);
                for (int j = 1; j <= k; j++) begin
                    tick();
                    bus.drv_busy = mode[0];
                    check("wr_line1", bus.drv_first_line, exp1);
                end
                tick();
                bus.drv_busy = 1'b0;
                bus.drv_done = 1'b1;
                d = cyc_n;
                tick();
                bus.drv_done = 1'b0;
                check("done_err", 128'(err), 128'(err_m));
                check("done_grant", 128'(grant), 128'(0));
                check("done_start", 128'(bus.drv_start), 128'(0));
                check("done_line2", bus.drv_second_line, exp2);
                idle_from = d + H + 1;
                hold_next = 1;
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
